dp_debug_ctrl: RTL

Parametrised run/halt/single-step controller and probe unit for the single-cycle MIPS datapath on the Basys 2 board. It generalises the fixed three-channel switch-injection muxes into N channels with a configurable injection width. It adds a breakpoint comparator, a single-step FSM that drives the CPU clock enable, shadow capture of probed values, and a rotating display selector for the seven-segment driver. It sits between the board I/O (debounced buttons, switches) and the datapath, whose PC register and register file are gated by `cpu_en`.

---
 rtl/dp_debug_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/dp_debug_ctrl.sv
// dp_debug_ctrl: run/halt/single-step controller and probe unit for the
// single-cycle MIPS datapath. It does four things:
// - per-channel switch injection;
// - a HALT/STEP/RUN FSM that drives the CPU clock enable;
// - shadow capture of the probed values;
// - a rotating seven-segment display selector.
// Optional feature: define DP_DEBUG_BP_EN to build in the breakpoint
// comparator and its resume-skip logic. Without it, RUN only leaves on halt_req.

// One probe channel: switch injection on the low INJ_W bits plus a shadow copy
// captured whenever the CPU executes.
module dp_debug_lane #(
  parameter int WIDTH = 32,
  parameter int INJ_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] probe_in,
  input  logic             inj_sel,
  input  logic [INJ_W-1:0] inj_data,
  output logic [WIDTH-1:0] probe_out,
  output logic [WIDTH-1:0] shadow
);

  generate
    if (INJ_W < WIDTH) begin : g_part
      assign probe_out = {probe_in[WIDTH-1:INJ_W],
                          inj_sel ? inj_data : probe_in[INJ_W-1:0]};
    end else begin : g_full
      assign probe_out = inj_sel ? inj_data : probe_in;
    end
  endgenerate

  // Shadow follows the value the datapath saw on each executed cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  shadow <= '0;
    else if (en) shadow <= probe_out;
  end

endmodule

module dp_debug_ctrl #(
  parameter int WIDTH    = 32,
  parameter int NCH      = 3,
  parameter int INJ_W    = 8,
  parameter int DISP_W   = 16,
  parameter int SCAN_DIV = 24,
  parameter int SEL_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run_req,
  input  logic                 step_req,
  input  logic                 halt_req,
  input  logic                 bp_en,
  input  logic [WIDTH-1:0]     bp_addr,
  input  logic [WIDTH-1:0]     pc,
  input  logic [NCH*WIDTH-1:0] probe_in,
  input  logic [NCH-1:0]       inj_sel,
  input  logic [INJ_W-1:0]     inj_data,
  output logic [NCH*WIDTH-1:0] probe_out,
  output logic                 cpu_en,
  output logic                 halted,
  output logic [SEL_W-1:0]     disp_sel,
  output logic [DISP_W-1:0]    disp_data,
  output logic [31:0]          cycle_count
);

  typedef enum logic [1:0] {S_HALT, S_STEP, S_RUN} state_t;

  state_t                        state, state_n;
  logic                          bp_hit;
  logic [NCH-1:0][WIDTH-1:0]     shadow;
  logic [SCAN_DIV-1:0]           div;
  logic [31:0]                   cnt_q;

  assign cycle_count = cnt_q;

  genvar k;
  generate
    for (k = 0; k < NCH; k++) begin : g_lane
      dp_debug_lane #(.WIDTH(WIDTH), .INJ_W(INJ_W)) u_lane (
        .clk       (clk),
        .reset     (reset),
        .en        (cpu_en),
        .probe_in  (probe_in[k*WIDTH +: WIDTH]),
        .inj_sel   (inj_sel[k]),
        .inj_data  (inj_data),
        .probe_out (probe_out[k*WIDTH +: WIDTH]),
        .shadow    (shadow[k])
      );
    end
  endgenerate

`ifdef DP_DEBUG_BP_EN
  logic bp_skip;

  // The PC we resume from must execute once even if it is the breakpoint.
  assign bp_hit = (state == S_RUN) && bp_en && (pc == bp_addr) && !bp_skip;

  // Arm the skip on leaving HALT; drop it after the first executed cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                bp_skip <= 1'b0;
    else if (state == S_HALT && state_n != S_HALT) bp_skip <= 1'b1;
    else if (cpu_en)                           bp_skip <= 1'b0;
  end
`else
  logic unused_bp;
  assign unused_bp = ^{bp_en, bp_addr};
  assign bp_hit    = 1'b0;
`endif

  // State register; halted mirrors whether the next state is HALT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_HALT;
      halted <= 1'b1;
    end else begin
      state  <= state_n;
      halted <= (state_n == S_HALT);
    end
  end

  // Next state and enable; halt_req beats step_req beats run_req.
  always_comb begin
    state_n = state;
    cpu_en  = 1'b0;
    unique case (state)
      S_HALT: begin
        if (halt_req)      state_n = S_HALT;
        else if (step_req) state_n = S_STEP;
        else if (run_req)  state_n = S_RUN;
      end
      S_STEP: begin
        cpu_en  = 1'b1;
        state_n = S_HALT;
      end
      S_RUN: begin
        cpu_en = !halt_req && !bp_hit;
        if (halt_req || bp_hit) state_n = S_HALT;
      end
      default: state_n = S_HALT;
    endcase
  end

  // Executed-cycle counter, free to wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      cnt_q <= '0;
    else if (cpu_en) cnt_q <= cnt_q + 32'd1;
  end

  // Free-running scan divider; the display channel rotates on its wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div      <= '0;
      disp_sel <= '0;
    end else begin
      div <= div + SCAN_DIV'(1);
      if (div == '1)
        disp_sel <= (disp_sel == SEL_W'(NCH-1)) ? '0 : disp_sel + SEL_W'(1);
    end
  end

  // Low part of the selected shadow for the seven-segment driver.
  always_comb begin
    disp_data = '0;
    for (int i = 0; i < NCH; i++)
      if (disp_sel == SEL_W'(i)) disp_data = shadow[i][DISP_W-1:0];
  end

endmodule
